// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: class and extension
// nibbles, loader states and the decoded-field bundle.
package instr_encoder_loader_pkg;

    localparam logic [3:0] CLS_RTYPE   = 4'b0000;
    localparam logic [3:0] CLS_SPECIAL = 4'b0100;
    localparam logic [3:0] CLS_SHIFT   = 4'b1000;
    localparam logic [3:0] CLS_BCOND   = 4'b1100;

    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;
    localparam logic [3:0] EXT_JAL  = 4'b1000;
    localparam logic [3:0] EXT_LSH  = 4'b0100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_FULL  = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] op;
        logic [3:0] rega;
        logic [3:0] regb;
        logic [7:0] imm;
        logic [3:0] flag;
    } fields_t;

    // A shift immediate fits when its upper nibble is the sign extension of bit 3.
    function automatic logic imm_fits_nibble(input logic [7:0] imm);
        return imm[7:4] == {4{imm[3]}};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and memory write port of the instruction loader.
interface instr_encoder_loader_if #(parameter int ADDR_W = 16);

    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [7:0]        in_op;
    logic [3:0]        in_rega;
    logic [3:0]        in_regb;
    logic [7:0]        in_imm;
    logic [3:0]        in_flag;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output in_valid, in_last, in_op, in_rega, in_regb, in_imm, in_flag,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_last, in_op, in_rega, in_regb, in_imm, in_flag,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/instr_encoder_loader_pack.sv
// instr_pack: combinational field-to-word packer, the single home of the
// encoding table, plus a flag for shift immediates that do not fit 4 bits.
module instr_pack
    import instr_encoder_loader_pkg::*;
(
    input  fields_t     fields,
    output logic [15:0] word,
    output logic        imm_trunc
);

    logic [3:0] cls_s;
    logic [3:0] ext_s;

    assign cls_s = fields.op[7:4];
    assign ext_s = fields.op[3:0];

    // Any class with a nonzero low bit pair is an immediate format.
    always_comb begin
        word      = 16'h0000;
        imm_trunc = 1'b0;
        if (cls_s[1] | cls_s[0]) begin
            word = {cls_s, fields.regb, fields.imm};
        end else begin
            case (cls_s)
                CLS_RTYPE: begin
                    word = {CLS_RTYPE, fields.regb, ext_s, fields.rega};
                end
                CLS_SPECIAL: begin
                    case (ext_s)
                        EXT_LOAD, EXT_STOR, EXT_JAL:
                            word = {CLS_SPECIAL, fields.regb, ext_s, fields.rega};
                        default:
                            word = {CLS_SPECIAL, fields.flag, ext_s, fields.rega};
                    endcase
                end
                CLS_SHIFT: begin
                    if (ext_s == EXT_LSH) begin
                        word = {CLS_SHIFT, fields.regb, ext_s, fields.rega};
                    end else begin
                        word      = {CLS_SHIFT, fields.regb, ext_s, fields.imm[3:0]};
                        imm_trunc = !imm_fits_nibble(fields.imm);
                    end
                end
                CLS_BCOND: begin
                    word = {CLS_BCOND, fields.flag, fields.imm};
                end
                default: begin
                    word = 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields and streams them into instruction memory
// at an auto-incrementing address. Optional XOR checksum: INSTR_ENC_CHECKSUM_EN.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_W-1:0]     count,
    output logic                  busy,
    output logic                  done,
    output logic                  full,
    output logic                  err
`ifdef INSTR_ENC_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    // One spare bit so a session of exactly 2^ADDR_W words is representable.
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t            state_r;
    state_t            state_nx;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     occupied_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [15:0]       mem_wdata_r;
    logic [15:0]       word_s;
    logic              mem_we_r;
    logic              done_r;
    logic              full_r;
    logic              err_r;
    logic              imm_trunc_s;
    logic              accept_s;
    logic              in_ready_s;
    logic              busy_s;
    logic              last_slot_s;
    fields_t           fields_s;

    assign fields_s = '{op:   bus.in_op,
                        rega: bus.in_rega,
                        regb: bus.in_regb,
                        imm:  bus.in_imm,
                        flag: bus.in_flag};

    instr_pack u_pack (
        .fields    (fields_s),
        .word      (word_s),
        .imm_trunc (imm_trunc_s)
    );

    // The word being written this cycle is not yet counted but holds a slot.
    assign occupied_s  = count_r + CW'(mem_we_r);
    assign last_slot_s = (occupied_s + CW'(1)) == DEPTH_C;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; start wins over everything else.
    always_comb begin
        state_nx = state_r;
        if (start) begin
            state_nx = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE:  state_nx = ST_IDLE;
                ST_LOAD: begin
                    if (accept_s && bus.in_last) begin
                        state_nx = ST_DRAIN;
                    end else if (accept_s && last_slot_s) begin
                        state_nx = ST_FULL;
                    end else begin
                        state_nx = ST_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (mem_we_r) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_DRAIN;
                    end
                end
                ST_DONE:  state_nx = ST_DONE;
                ST_FULL:  state_nx = ST_FULL;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // State-decoded handshake and status.
    always_comb begin
        in_ready_s = (state_r == ST_LOAD) && (occupied_s < DEPTH_C);
        busy_s     = (state_r == ST_LOAD) || (state_r == ST_DRAIN);
        accept_s   = bus.in_valid && in_ready_s && !start;
    end

    // Write stage, address/count bookkeeping and sticky status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_r      <= '0;
            count_r     <= '0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 16'h0000;
            done_r      <= 1'b0;
            full_r      <= 1'b0;
            err_r       <= 1'b0;
        end else if (start) begin
            addr_r   <= base_addr;
            count_r  <= '0;
            mem_we_r <= 1'b0;
            done_r   <= 1'b0;
            full_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (mem_we_r) begin
                count_r <= count_r + CW'(1);
            end
            mem_we_r <= accept_s;
            if (accept_s) begin
                mem_addr_r  <= addr_r;
                mem_wdata_r <= word_s;
                addr_r      <= addr_r + ADDR_W'(1);
                if (imm_trunc_s) begin
                    err_r <= 1'b1;
                end
            end
            if ((state_r == ST_DRAIN) && mem_we_r) begin
                done_r <= 1'b1;
            end
            if ((state_r == ST_FULL) && mem_we_r) begin
                full_r <= 1'b1;
            end
        end
    end

`ifdef INSTR_ENC_CHECKSUM_EN
    logic [15:0] checksum_r;

    // Running XOR, advanced with the word so it moves together with mem_we.
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum_r <= 16'h0000;
        end else if (start) begin
            checksum_r <= 16'h0000;
        end else if (accept_s) begin
            checksum_r <= checksum_r ^ word_s;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum = checksum_r;
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign count         = count_r[ADDR_W-1:0];
    assign busy          = busy_s;
    assign done          = done_r;
    assign full          = full_r;
    assign err           = err_r;

endmodule
